// File: rtl/debounce_multi.sv
// Multi-channel key/switch debouncer.
// Each channel synchronises its raw input through two flops, waits for the
// synchronised level to stay unchanged for NUMBER cycles, and then moves the
// registered debounced level key_o.  Single-cycle rise/fall pulses mark each
// key_o change.  A one-shot key_hold pulse fires once per press after key_o
// has stayed ACTIVE for HOLD_NUMBER cycles.
// Every output is a flop, so nothing in the downstream logic sees a
// combinational path from the asynchronous key inputs.
module debounce_multi #(
    parameter int unsigned       NCH         = 4,
    parameter int unsigned       NBITS       = 24,
    parameter logic [NBITS-1:0]  NUMBER      = 24'd10_000_000,
    parameter int unsigned       HBITS       = 28,
    parameter logic [HBITS-1:0]  HOLD_NUMBER = 28'd100_000_000,
    parameter logic              ACTIVE      = 1'b1,
    parameter logic              INIT        = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] key_i,
    output logic [NCH-1:0] key_o,
    output logic [NCH-1:0] key_rise,
    output logic [NCH-1:0] key_fall,
    output logic [NCH-1:0] key_hold
);

    // Synchroniser stages
    logic [NCH-1:0]   s1_q, s1_d;
    logic [NCH-1:0]   s2_q, s2_d;

    // Stability tracking: last seen synchronised level and how long it has held
    logic [NCH-1:0]   key_m_q, key_m_d;
    logic [NBITS-1:0] cnt_q [NCH];
    logic [NBITS-1:0] cnt_d [NCH];

    // Debounced level and its edge pulses
    logic [NCH-1:0]   key_o_q, key_o_d;
    logic [NCH-1:0]   rise_q, rise_d;
    logic [NCH-1:0]   fall_q, fall_d;

    // Long-press detection
    logic [HBITS-1:0] hcnt_q [NCH];
    logic [HBITS-1:0] hcnt_d [NCH];
    logic [NCH-1:0]   hold_done_q, hold_done_d;
    logic [NCH-1:0]   hold_q, hold_d;

    // Two-flop synchroniser: the raw input is only ever looked at by s1.
    always_comb begin
        s1_d = key_i;
        s2_d = s1_q;
    end

    // Stability window: any change on s2 restarts the count; once the count
    // has saturated at NUMBER the debounced level is allowed to follow key_m.
    always_comb begin
        key_m_d = key_m_q;
        key_o_d = key_o_q;
        cnt_d   = cnt_q;
        for (int n = 0; n < NCH; n++) begin
            if (s2_q[n] != key_m_q[n]) begin
                key_m_d[n] = s2_q[n];
                cnt_d[n]   = '0;
            end else if (cnt_q[n] == NUMBER) begin
                if (key_o_q[n] != key_m_q[n]) begin
                    key_o_d[n] = key_m_q[n];
                end
            end else begin
                cnt_d[n] = cnt_q[n] + NBITS'(1);
            end
        end
    end

    // Edge pulses are registered together with the new key_o, so they are
    // high exactly in the first cycle the new level is visible.
    always_comb begin
        rise_d = ~key_o_q &  key_o_d;
        fall_d =  key_o_q & ~key_o_d;
    end

    // Long-press: the count runs only while key_o is already ACTIVE, and the
    // release is detected on the next key_o so the hold state clears on the
    // same edge that produces the release pulse.
    always_comb begin
        hcnt_d      = hcnt_q;
        hold_done_d = hold_done_q;
        hold_d      = '0;
        for (int n = 0; n < NCH; n++) begin
            if (key_o_d[n] != ACTIVE) begin
                hcnt_d[n]      = '0;
                hold_done_d[n] = 1'b0;
            end else if (key_o_q[n] == ACTIVE) begin
                if (hcnt_q[n] == HOLD_NUMBER) begin
                    if (!hold_done_q[n]) begin
                        hold_d[n]      = 1'b1;
                        hold_done_d[n] = 1'b1;
                    end
                end else begin
                    hcnt_d[n] = hcnt_q[n] + HBITS'(1);
                end
            end
        end
    end

    // Synchroniser flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= {NCH{INIT}};
            s2_q <= {NCH{INIT}};
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Stability counter, debounced level and edge pulse flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_m_q <= {NCH{INIT}};
            key_o_q <= {NCH{INIT}};
            rise_q  <= '0;
            fall_q  <= '0;
            for (int n = 0; n < NCH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            key_m_q <= key_m_d;
            key_o_q <= key_o_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int n = 0; n < NCH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Long-press counter and one-shot flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_done_q <= '0;
            hold_q      <= '0;
            for (int n = 0; n < NCH; n++) begin
                hcnt_q[n] <= '0;
            end
        end else begin
            hold_done_q <= hold_done_d;
            hold_q      <= hold_d;
            for (int n = 0; n < NCH; n++) begin
                hcnt_q[n] <= hcnt_d[n];
            end
        end
    end

    assign key_o    = key_o_q;
    assign key_rise = rise_q;
    assign key_fall = fall_q;
    assign key_hold = hold_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi (NCH=4, NUMBER=4, HOLD_NUMBER=10, INIT=0, ACTIVE=1).
// The reference model keeps the full history of sampled inputs and decides the
// debounced level from a sliding window over that history; press length is
// tracked as an age counted from the rise.
module tb_debounce_multi;
    localparam int NUM  = 4;
    localparam int HOLD = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_i = 4'b0;
    logic [3:0] key_o, key_rise, key_fall, key_hold;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [3:0] hist [$];
    logic [3:0] m_o, m_rise, m_fall, m_hold;
    int         age [4];

    debounce_multi #(
        .NCH(4), .NBITS(3), .NUMBER(3'd4), .HBITS(4), .HOLD_NUMBER(4'd10),
        .ACTIVE(1'b1), .INIT(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .key_i(key_i),
        .key_o(key_o), .key_rise(key_rise), .key_fall(key_fall), .key_hold(key_hold)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] samp(input int i);
        if (i < 0) return 4'b0;
        return hist[i];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_o = '0; m_rise = '0; m_fall = '0; m_hold = '0;
        for (int n = 0; n < 4; n++) age[n] = 0;
    endtask

    // Drive one input sample, advance one edge, update the model, settle 1ns.
    // The debounced level takes sample t-2 when the NUMBER+2 samples
    // t-3-NUM .. t-2 all agree.
    task automatic tick(input logic [3:0] k);
        logic [3:0] new_o, s, ref_s;
        int t;
        logic eq;
        key_i = k;
        @(posedge clk);
        hist.push_back(k);
        t = hist.size() - 1;
        new_o = m_o;
        ref_s = samp(t - 2);
        for (int n = 0; n < 4; n++) begin
            eq = 1'b1;
            for (int j = t - 3 - NUM; j <= t - 2; j++) begin
                s = samp(j);
                if (s[n] !== ref_s[n]) eq = 1'b0;
            end
            if (eq) new_o[n] = ref_s[n];
        end
        m_rise = ~m_o & new_o;
        m_fall = m_o & ~new_o;
        for (int n = 0; n < 4; n++) begin
            m_hold[n] = 1'b0;
            if (new_o[n]) begin
                if (m_o[n]) age[n] = age[n] + 1;
                else        age[n] = 0;
                if (age[n] == HOLD + 1) m_hold[n] = 1'b1;
            end else begin
                age[n] = 0;
            end
        end
        m_o = new_o;
        #1;
    endtask

    task automatic apply_reset();
        key_i = 4'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        key_i = 4'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({key_o, key_rise, key_fall, key_hold} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got %h want 0000", {key_o, key_rise, key_fall, key_hold});
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== 16'h0) begin
                errors++;
                $display("FAIL idle_zero i=%0d got %h want 0000", i, {key_o, key_rise, key_fall, key_hold});
            end
        end
    endtask

    task automatic test_single_rise();
        int rise_edge, rise_cnt;
        rise_edge = -1; rise_cnt = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            tick(4'b0001);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL single_rise i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
            if (key_rise[0]) begin rise_edge = i; rise_cnt++; end
        end
        checks++;
        if (rise_edge !== 7 || rise_cnt !== 1) begin
            errors++;
            $display("FAIL single_rise_edge got edge %0d count %0d want edge 7 count 1", rise_edge, rise_cnt);
        end
        checks++;
        if (key_o !== 4'b0001) begin
            errors++;
            $display("FAIL single_rise_level got %b want 0001", key_o);
        end
    endtask

    task automatic test_bounce();
        int rise_edge, rise_cnt;
        logic [3:0] k;
        rise_edge = -1; rise_cnt = 0;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            // 1,0,1,0 in 2-cycle segments, then 1 from sample 8 onward
            k = (i >= 8 || (i / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(k);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL bounce i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
            if (key_rise[1]) begin rise_edge = i; rise_cnt++; end
        end
        checks++;
        if (rise_edge !== 15 || rise_cnt !== 1) begin
            errors++;
            $display("FAIL bounce_edge got edge %0d count %0d want edge 15 count 1", rise_edge, rise_cnt);
        end
    endtask

    task automatic test_hold();
        int rise_edge, hold_edge, hold_cnt, fall_edge, fall_cnt;
        rise_edge = -1; hold_edge = -1; hold_cnt = 0; fall_edge = -1; fall_cnt = 0;
        apply_reset();
        for (int i = 0; i < 56; i++) begin
            tick(i < 40 ? 4'b0100 : 4'b0000);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL hold i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
            if (key_rise[2]) rise_edge = i;
            if (key_hold[2]) begin hold_edge = i; hold_cnt++; end
            if (key_fall[2]) begin fall_edge = i; fall_cnt++; end
        end
        checks++;
        if (hold_cnt !== 1 || hold_edge - rise_edge !== 11 || hold_edge !== 18) begin
            errors++;
            $display("FAIL hold_once got count %0d edge %0d rise %0d want count 1 edge 18 rise 7",
                     hold_cnt, hold_edge, rise_edge);
        end
        checks++;
        if (fall_cnt !== 1 || fall_edge !== 47) begin
            errors++;
            $display("FAIL hold_release got count %0d edge %0d want count 1 edge 47", fall_cnt, fall_edge);
        end
    endtask

    task automatic test_reset_mid();
        int rise_cnt, rise_edge;
        rise_cnt = 0; rise_edge = -1;
        apply_reset();
        // Press channel 3, then release so a new window and the hold age are both in flight
        for (int i = 0; i < 14; i++) begin
            tick(i < 10 ? 4'b1000 : 4'b0000);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL reset_mid_pre i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
        end
        checks++;
        if (key_o !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_setup got %b want 1000", key_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({key_o, key_rise, key_fall, key_hold} !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got %h want 0000", {key_o, key_rise, key_fall, key_hold});
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        // A 4-sample glitch must not pass, then a steady press must
        for (int i = 0; i < 24; i++) begin
            tick((i < 4 || i >= 8) ? 4'b1000 : 4'b0000);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL reset_mid_post i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
            if (key_rise[3]) begin rise_cnt++; rise_edge = i; end
        end
        checks++;
        if (rise_cnt !== 1 || rise_edge !== 15) begin
            errors++;
            $display("FAIL reset_mid_rise got count %0d edge %0d want count 1 edge 15", rise_cnt, rise_edge);
        end
    endtask

    task automatic test_simultaneous();
        int e0, e3;
        e0 = -1; e3 = -1;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            tick(4'b1001);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL simult i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
            if (key_rise[0]) e0 = i;
            if (key_rise[3]) e3 = i;
        end
        checks++;
        if (e0 !== 7 || e3 !== 7) begin
            errors++;
            $display("FAIL simult_edge got ch0 %0d ch3 %0d want 7 and 7", e0, e3);
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        k = 4'b0;
        apply_reset();
        for (int i = 0; i < 900; i++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(11) == 0) k[n] = ~k[n];
            end
            if (i == 450) begin
                apply_reset();
            end
            tick(k);
            checks++;
            if ({key_o, key_rise, key_fall, key_hold} !== {m_o, m_rise, m_fall, m_hold}) begin
                errors++;
                $display("FAIL random i=%0d got %h want %h", i,
                         {key_o, key_rise, key_fall, key_hold}, {m_o, m_rise, m_fall, m_hold});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_rise();
        test_bounce();
        test_hold();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
